bullet_controller: RTL and testbench
====================================

// Module: bullet_controller
// PURPOSE
//  Upstream stage of the colour mapper: owns one tank's 3-slot bullet pool. Latches fire requests,
//  spawns bullets at the tank centre with heading sin/cos, moves them once per frame in fixed
//  point, bounces (or kills) them at screen edges, retires on lifetime expiry. Drives Bullet1..3
//  X/Y/S + is_bulletN_active straight into the colour mapper's bullet inputs.
// PARAMETERS
//  SPEED        2    bullet speed, integer pixels/frame along heading (1..7)
//  BULLET_SIZE  2    half-width in pixels, driven on BulletNS
//  LIFE_FRAMES  300  frames a bullet lives after spawn (1..1023)
//  COOLDOWN     15   frames after a spawn during which fire is ignored (0..255)
//  X_MAX        639  rightmost visible pixel; Y_MAX 479 bottom pixel
// PORTS
//  CLK                  in   1   system clock (50 MHz)
//  Reset_n              in   1   asynchronous active-low reset
//  frame_clk            in   1   VGA vsync, async to nothing but treated as level; rising edge = frame tick
//  fire                 in   1   fire key level; rising edge = request
//  TankX, TankY         in   10  tank centre, pixels
//  sin_t, cos_t         in   8   heading, signed Q1.6 (+64 = +1.0)
//  Bullet1X..Bullet3X   out  10  bullet centre X, pixels
//  Bullet1Y..Bullet3Y   out  10  bullet centre Y, pixels
//  Bullet1S..Bullet3S   out  10  constant BULLET_SIZE
//  is_bullet1..3_active out  1   slot live
// BEHAVIOUR
//  Reset (async, Reset_n=0): all slots inactive, X/Y=0, life=0, cooldown=0, pending=0, sync flops=0.
//   Release mid-frame: first tick is the next clean rising edge of synchronised frame_clk.
//  Tick: frame_clk through 2-flop sync; tick = sync & ~prev, one CLK wide, 3 CLK after edge.
//  Fire: fire rising edge (same 2-flop sync + edge) sets pending. Pending is cleared on every tick.
//   Edge in the same cycle as tick counts for that tick. Multiple edges per frame = one request.
//  Per-slot state: pos X,Y unsigned 16b (10.6); vel vx,vy signed 12b (Q.6); life 10b; active.
//  State machine (top): IDLE -> UPDATE on tick; UPDATE (1 cyc: move/retire all slots in parallel)
//   -> SPAWN (1 cyc) -> IDLE. Outputs registered; new values visible 2 CLK after tick.
//  UPDATE, each active slot: life-=1; if life becomes 0 -> inactive, X/Y held.
//   else nx = X + sext(vx), ny = Y + sext(vy) in signed 18b.
//   Edge test on integer part: nx<BULLET_SIZE or nx>X_MAX-BULLET_SIZE (same for Y with Y_MAX).
//   On edge hit: with BULLET_BOUNCE_EN negate that axis velocity and clamp pos to the limit;
//   without it slot goes inactive. Both axes hit same frame: both handled independently.
//  SPAWN: if pending_at_tick && cooldown==0 && any slot free: lowest-index free slot gets
//   X={TankX,6'b0}, Y={TankY,6'b0}, vx=cos_t*SPEED, vy=-(sin_t*SPEED) (screen Y down),
//   life=LIFE_FRAMES, active=1; cooldown=COOLDOWN. Spawned slot not moved this frame.
//   All slots busy or cooldown>0: request dropped silently.
//  Cooldown: decrements by 1 each tick when >0 (in UPDATE, before SPAWN check).
//  Slot freed in UPDATE is reusable by SPAWN of the same tick.
//  Width: cos_t*SPEED fits 11b signed; sext to 18b for add; no wrap past 0/1023 possible since
//   edge test catches before store. Inputs sampled in SPAWN cycle only.
// CONFIGURATION
//  BULLET_BOUNCE_EN defined: edge hit reflects velocity (tank-trouble rules), bullet lives to
//   LIFE_FRAMES. Undefined: edge hit retires the bullet immediately; no reflection logic built.
// TESTING
//  Reset: Reset_n=0 mid-frame -> all active=0, X/Y=0 within 0 CLK (async); no spawn on 1st tick.
//  Spawn: TankX=320,TankY=240,cos=64,sin=0,fire edge, tick -> slot1 active, (320,240);
//   next tick -> (322,240); after 10 ticks (340,240).
//  Pool/cooldown: COOLDOWN=0, fire every frame x4 -> slots1..3 active, 4th dropped; slot2 retire
//   then fire -> slot2 reused (lowest free).
//  Cooldown: COOLDOWN=15, fire at frames 0 and 5 -> only one bullet; fire at frame 16 -> second.
//  Edge: X=637,vx=+2,size=2: BOUNCE_EN -> X clamped 637, vx=-2, next tick 635; else active=0.
//  Lifetime: LIFE_FRAMES=3, sin=0,cos=0 -> active exactly 3 ticks then 0; fire+tick same
//   cycle -> spawn on that tick.

Source files
------------

// File: rtl/bullet_controller.sv
// ---------------------------------------------------------------------------
// bullet_controller
//   Owns one tank's 3-slot bullet pool ahead of the colour mapper. It latches
//   fire requests and spawns bullets at the tank centre along the tank heading.
//   Bullets move once per frame in 10.6 fixed point. At a screen edge a bullet
//   either bounces or is retired, and every bullet retires when its lifetime
//   runs out.
//
//   Optional feature macro: BULLET_BOUNCE_EN
//     defined   : an edge hit reflects that axis velocity and clamps to the limit
//     undefined : an edge hit retires the bullet (no reflection logic built)
//
// Parameters
//   SPEED        bullet speed, integer pixels/frame along heading (1..7)
//   BULLET_SIZE  half-width in pixels, driven on BulletNS
//   LIFE_FRAMES  frames a bullet lives after spawn (1..1023)
//   COOLDOWN     frames after a spawn during which fire is ignored (0..255)
//   X_MAX/Y_MAX  rightmost / bottom visible pixel
//
// Ports
//   CLK                    system clock
//   Reset_n                asynchronous active-low reset
//   frame_clk              vsync level; a rising edge is a frame tick
//   fire                   fire key level; a rising edge is a request
//   TankX, TankY           tank centre, pixels
//   sin_t, cos_t           heading, signed Q1.6 (+64 = +1.0)
//   BulletNX/NY            bullet centre, pixels (registered)
//   BulletNS               constant BULLET_SIZE
//   is_bulletN_active      slot live
//   dbg_state              current frame-sequencer state
// ---------------------------------------------------------------------------
module bullet_controller #(
  parameter int SPEED       = 2,
  parameter int BULLET_SIZE = 2,
  parameter int LIFE_FRAMES = 300,
  parameter int COOLDOWN    = 15,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [7:0] sin_t,
  input  logic [7:0] cos_t,
  output logic [9:0] Bullet1X,
  output logic [9:0] Bullet1Y,
  output logic [9:0] Bullet1S,
  output logic [9:0] Bullet2X,
  output logic [9:0] Bullet2Y,
  output logic [9:0] Bullet2S,
  output logic [9:0] Bullet3X,
  output logic [9:0] Bullet3Y,
  output logic [9:0] Bullet3S,
  output logic       is_bullet1_active,
  output logic       is_bullet2_active,
  output logic       is_bullet3_active,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_SPAWN  = 2'd2
  } state_t;

  localparam logic signed [11:0] EDGE_LO   = 12'(BULLET_SIZE);
  localparam logic signed [11:0] EDGE_HI_X = 12'(X_MAX - BULLET_SIZE);
  localparam logic signed [11:0] EDGE_HI_Y = 12'(Y_MAX - BULLET_SIZE);
  localparam logic signed [11:0] SPEED_S   = 12'(SPEED);
`ifdef BULLET_BOUNCE_EN
  localparam logic [15:0] CLAMP_LO   = {EDGE_LO[9:0], 6'b0};
  localparam logic [15:0] CLAMP_HI_X = {EDGE_HI_X[9:0], 6'b0};
  localparam logic [15:0] CLAMP_HI_Y = {EDGE_HI_Y[9:0], 6'b0};
`endif

  state_t state, state_nxt;

  // ---------------- input synchronisers and edge detect --------------------
  // prime marks when the sync stages hold real samples. The armed flags only
  // open once the synchronised level has been seen low, so a level already
  // high at reset release does not count as an edge.
  logic [1:0] prime;
  logic [2:0] frame_sync, fire_sync;
  logic       frame_armed, fire_armed;
  logic       tick, fire_edge;
  logic       pending, req;

  assign tick      = frame_armed & frame_sync[1] & ~frame_sync[2];
  assign fire_edge = fire_armed  & fire_sync[1]  & ~fire_sync[2];

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      prime       <= '0;
      frame_sync  <= '0;
      fire_sync   <= '0;
      frame_armed <= 1'b0;
      fire_armed  <= 1'b0;
      pending     <= 1'b0;
      req         <= 1'b0;
    end else begin
      prime       <= {prime[0], 1'b1};
      frame_sync  <= {frame_sync[1:0], frame_clk};
      fire_sync   <= {fire_sync[1:0], fire};
      frame_armed <= frame_armed | (prime[1] & ~frame_sync[1]);
      fire_armed  <= fire_armed  | (prime[1] & ~fire_sync[1]);
      // A fire edge coinciding with the tick belongs to that tick's request.
      if (tick) begin
        req     <= pending | fire_edge;
        pending <= 1'b0;
      end else if (fire_edge) begin
        pending <= 1'b1;
      end
    end
  end

  // ---------------- frame sequencer ----------------------------------------
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (tick) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_SPAWN;
      S_SPAWN:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  // ---------------- slot state ---------------------------------------------
  logic [15:0]        pos_x [3];
  logic [15:0]        pos_y [3];
  logic signed [11:0] vel_x [3];
  logic signed [11:0] vel_y [3];
  logic [9:0]         life  [3];
  logic               active[3];
  logic [7:0]         cooldown;

  logic signed [17:0] sum_x [3];
  logic signed [17:0] sum_y [3];
  logic signed [11:0] int_x [3];
  logic signed [11:0] int_y [3];
  logic               hit_x [3];
  logic               hit_y [3];
  logic [15:0]        upd_x [3];
  logic [15:0]        upd_y [3];
  logic signed [11:0] upd_vx[3];
  logic signed [11:0] upd_vy[3];
  logic [9:0]         upd_life[3];
  logic               upd_active[3];

  // Move/retire computation for all three slots in parallel. The position is
  // widened to 18b signed so a step past 0 shows up as a negative integer part
  // and is caught by the edge test before anything is stored.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum_x[i]      = $signed({2'b00, pos_x[i]}) + $signed({{6{vel_x[i][11]}}, vel_x[i]});
      sum_y[i]      = $signed({2'b00, pos_y[i]}) + $signed({{6{vel_y[i][11]}}, vel_y[i]});
      int_x[i]      = sum_x[i][17:6];
      int_y[i]      = sum_y[i][17:6];
      hit_x[i]      = (int_x[i] < EDGE_LO) || (int_x[i] > EDGE_HI_X);
      hit_y[i]      = (int_y[i] < EDGE_LO) || (int_y[i] > EDGE_HI_Y);
      upd_x[i]      = pos_x[i];
      upd_y[i]      = pos_y[i];
      upd_vx[i]     = vel_x[i];
      upd_vy[i]     = vel_y[i];
      upd_life[i]   = life[i];
      upd_active[i] = active[i];
      if (active[i]) begin
        upd_life[i] = life[i] - 10'd1;
        if (life[i] == 10'd1) begin
          upd_active[i] = 1'b0;
        end
`ifdef BULLET_BOUNCE_EN
        else begin
          // Each axis reflects independently; a corner hit flips both.
          if (hit_x[i]) begin
            upd_x[i]  = (int_x[i] < EDGE_LO) ? CLAMP_LO : CLAMP_HI_X;
            upd_vx[i] = -vel_x[i];
          end else begin
            upd_x[i]  = sum_x[i][15:0];
          end
          if (hit_y[i]) begin
            upd_y[i]  = (int_y[i] < EDGE_LO) ? CLAMP_LO : CLAMP_HI_Y;
            upd_vy[i] = -vel_y[i];
          end else begin
            upd_y[i]  = sum_y[i][15:0];
          end
        end
`else
        else if (hit_x[i] || hit_y[i]) begin
          upd_active[i] = 1'b0;
        end else begin
          upd_x[i] = sum_x[i][15:0];
          upd_y[i] = sum_y[i][15:0];
        end
`endif
      end
    end
  end

  // ---------------- spawn selection ----------------------------------------
  logic               spawn_ok;
  logic [1:0]         spawn_idx;
  logic signed [11:0] cos_ext, sin_ext, spawn_vx, spawn_vy;

  assign cos_ext  = {{4{cos_t[7]}}, cos_t};
  assign sin_ext  = {{4{sin_t[7]}}, sin_t};
  assign spawn_vx = cos_ext * SPEED_S;
  // Screen Y grows downward, so a positive sine moves the bullet up.
  assign spawn_vy = -(sin_ext * SPEED_S);

  always_comb begin
    spawn_idx = 2'd0;
    if      (!active[0]) spawn_idx = 2'd0;
    else if (!active[1]) spawn_idx = 2'd1;
    else                 spawn_idx = 2'd2;
    spawn_ok = req && (cooldown == 8'd0) && (!active[0] || !active[1] || !active[2]);
  end

  // UPDATE commits the parallel move and the cooldown step; SPAWN then sees
  // the freshly retired slots and the decremented cooldown.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 3; i++) begin
        pos_x[i]  <= '0;
        pos_y[i]  <= '0;
        vel_x[i]  <= '0;
        vel_y[i]  <= '0;
        life[i]   <= '0;
        active[i] <= 1'b0;
      end
      cooldown <= '0;
    end else begin
      case (state)
        S_UPDATE: begin
          for (int i = 0; i < 3; i++) begin
            pos_x[i]  <= upd_x[i];
            pos_y[i]  <= upd_y[i];
            vel_x[i]  <= upd_vx[i];
            vel_y[i]  <= upd_vy[i];
            life[i]   <= upd_life[i];
            active[i] <= upd_active[i];
          end
          if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
        end
        S_SPAWN: begin
          if (spawn_ok) begin
            pos_x[spawn_idx]  <= {TankX, 6'b0};
            pos_y[spawn_idx]  <= {TankY, 6'b0};
            vel_x[spawn_idx]  <= spawn_vx;
            vel_y[spawn_idx]  <= spawn_vy;
            life[spawn_idx]   <= 10'(LIFE_FRAMES);
            active[spawn_idx] <= 1'b1;
            cooldown          <= 8'(COOLDOWN);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs -------------------------------------------------
  assign Bullet1X = pos_x[0][15:6];
  assign Bullet1Y = pos_y[0][15:6];
  assign Bullet2X = pos_x[1][15:6];
  assign Bullet2Y = pos_y[1][15:6];
  assign Bullet3X = pos_x[2][15:6];
  assign Bullet3Y = pos_y[2][15:6];
  assign Bullet1S = 10'(BULLET_SIZE);
  assign Bullet2S = 10'(BULLET_SIZE);
  assign Bullet3S = 10'(BULLET_SIZE);
  assign is_bullet1_active = active[0];
  assign is_bullet2_active = active[1];
  assign is_bullet3_active = active[2];

endmodule

// File: tb/tb_bullet_controller.sv
// ---------------------------------------------------------------------------
// tb_bullet_controller
//   Three bullet_controller instances share clock, reset, frame clock and tank
//   inputs; each has its own fire key.
//     u_a : default parameters (spawn, motion, cooldown, edge, reset)
//     u_b : COOLDOWN=0, LIFE_FRAMES=8 (pool exhaustion and slot reuse)
//     u_c : COOLDOWN=0, LIFE_FRAMES=3 (lifetime, fire on the tick cycle)
//   Expected slot states are queued as stimulus is applied and compared after
//   each frame has been processed.
// ---------------------------------------------------------------------------
module tb_bullet_controller;

  // ---------------- clock / reset ------------------------------------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Reset_n;
  logic       frame_clk;
  logic       fire_a, fire_b, fire_c;
  logic [9:0] TankX, TankY;
  logic [7:0] sin_t, cos_t;

  logic [9:0] bx [3][3];
  logic [9:0] by [3][3];
  logic [9:0] bs [3][3];
  logic       act[3][3];
  logic [1:0] dbg[3];

  int checks = 0;
  int errors = 0;

  // {check_pos, inst[1:0], slot[1:0], active, x[9:0], y[9:0]}
  logic [25:0] exp_q[$];
  string       tag_q[$];

  bullet_controller u_a (
    .CLK(CLK), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire_a),
    .TankX(TankX), .TankY(TankY), .sin_t(sin_t), .cos_t(cos_t),
    .Bullet1X(bx[0][0]), .Bullet1Y(by[0][0]), .Bullet1S(bs[0][0]),
    .Bullet2X(bx[0][1]), .Bullet2Y(by[0][1]), .Bullet2S(bs[0][1]),
    .Bullet3X(bx[0][2]), .Bullet3Y(by[0][2]), .Bullet3S(bs[0][2]),
    .is_bullet1_active(act[0][0]), .is_bullet2_active(act[0][1]),
    .is_bullet3_active(act[0][2]), .dbg_state(dbg[0])
  );

  bullet_controller #(.COOLDOWN(0), .LIFE_FRAMES(8)) u_b (
    .CLK(CLK), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire_b),
    .TankX(TankX), .TankY(TankY), .sin_t(sin_t), .cos_t(cos_t),
    .Bullet1X(bx[1][0]), .Bullet1Y(by[1][0]), .Bullet1S(bs[1][0]),
    .Bullet2X(bx[1][1]), .Bullet2Y(by[1][1]), .Bullet2S(bs[1][1]),
    .Bullet3X(bx[1][2]), .Bullet3Y(by[1][2]), .Bullet3S(bs[1][2]),
    .is_bullet1_active(act[1][0]), .is_bullet2_active(act[1][1]),
    .is_bullet3_active(act[1][2]), .dbg_state(dbg[1])
  );

  bullet_controller #(.COOLDOWN(0), .LIFE_FRAMES(3)) u_c (
    .CLK(CLK), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire_c),
    .TankX(TankX), .TankY(TankY), .sin_t(sin_t), .cos_t(cos_t),
    .Bullet1X(bx[2][0]), .Bullet1Y(by[2][0]), .Bullet1S(bs[2][0]),
    .Bullet2X(bx[2][1]), .Bullet2Y(by[2][1]), .Bullet2S(bs[2][1]),
    .Bullet3X(bx[2][2]), .Bullet3Y(by[2][2]), .Bullet3S(bs[2][2]),
    .is_bullet1_active(act[2][0]), .is_bullet2_active(act[2][1]),
    .is_bullet3_active(act[2][2]), .dbg_state(dbg[2])
  );

  // ---------------- driver tasks -------------------------------------------
  // One frame: optional fire edge, frame_clk high long enough for the tick to
  // be processed, then both levels low again. With same_cycle the fire edge
  // and the frame edge are launched together.
  task automatic frame(input logic fa, input logic fb, input logic fc, input bit same_cycle);
    @(negedge CLK);
    fire_a = fa;
    fire_b = fb;
    fire_c = fc;
    if (!same_cycle) repeat (4) @(negedge CLK);
    frame_clk = 1'b1;
    repeat (10) @(negedge CLK);
    frame_clk = 1'b0;
    fire_a    = 1'b0;
    fire_b    = 1'b0;
    fire_c    = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic idle_frames(input int n);
    repeat (n) frame(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    Reset_n = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  // ---------------- scoreboard ---------------------------------------------
  task automatic expect_slot(input string tag, input int inst, input int slot,
                             input logic a, input int x, input int y, input logic chk_pos);
    exp_q.push_back({chk_pos, 2'(inst), 2'(slot), a, 10'(x), 10'(y)});
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    logic [25:0] e;
    logic [20:0] obs;
    logic [20:0] want;
    string       t;
    int          inst, slot;
    while (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      t    = tag_q.pop_front();
      inst = int'(e[24:23]);
      slot = int'(e[22:21]);
      obs  = {act[inst][slot], bx[inst][slot], by[inst][slot]};
      want = e[20:0];
      if (!e[25]) begin
        obs[19:0]  = '0;
        want[19:0] = '0;
      end
      checks++;
      assert (obs === want) else begin
        errors++;
        $error("FAIL %s observed act=%0b x=%0d y=%0d expected act=%0b x=%0d y=%0d",
               t, obs[20], obs[19:10], obs[9:0], want[20], want[19:10], want[9:0]);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    fire_a    = 1'b0;
    fire_b    = 1'b0;
    fire_c    = 1'b0;
    TankX     = 10'd320;
    TankY     = 10'd240;
    cos_t     = 8'd64;
    sin_t     = 8'd0;
    repeat (3) @(negedge CLK);

    // Reset state of every slot of every instance
    for (int i = 0; i < 3; i++)
      for (int s = 0; s < 3; s++)
        expect_slot($sformatf("reset_i%0d_s%0d", i, s), i, s, 1'b0, 0, 0, 1'b1);
    drain();
    Reset_n = 1'b1;
    repeat (5) @(negedge CLK);

    // Spawn and motion: (320,240) heading +X at 2 px/frame
    frame(1'b1, 1'b0, 1'b0, 1'b0);                         // frame 0
    expect_slot("spawn_s1", 0, 0, 1'b1, 320, 240, 1'b1);
    expect_slot("spawn_s2_free", 0, 1, 1'b0, 0, 0, 1'b1);
    expect_slot("spawn_s3_free", 0, 2, 1'b0, 0, 0, 1'b1);
    drain();
    check_val("size_out", 32'(bs[0][0]), 32'd2);
    check_val("state_idle", 32'(dbg[0]), 32'd0);
    idle_frames(1);                                         // frame 1
    expect_slot("move_1", 0, 0, 1'b1, 322, 240, 1'b1);
    drain();

    // Cooldown 15: fire at frame 5 and 14 dropped, fire at frame 16 spawns
    idle_frames(3);                                         // frames 2..4
    frame(1'b1, 1'b0, 1'b0, 1'b0);                         // frame 5
    expect_slot("cool_f5_s1", 0, 0, 1'b1, 330, 240, 1'b1);
    expect_slot("cool_f5_s2", 0, 1, 1'b0, 0, 0, 1'b1);
    drain();
    idle_frames(5);                                         // frames 6..10
    expect_slot("move_10", 0, 0, 1'b1, 340, 240, 1'b1);
    drain();
    idle_frames(3);                                         // frames 11..13
    frame(1'b1, 1'b0, 1'b0, 1'b0);                         // frame 14
    expect_slot("cool_f14_s2", 0, 1, 1'b0, 0, 0, 1'b1);
    drain();
    idle_frames(1);                                         // frame 15
    frame(1'b1, 1'b0, 1'b0, 1'b0);                         // frame 16
    expect_slot("cool_f16_s1", 0, 0, 1'b1, 352, 240, 1'b1);
    expect_slot("cool_f16_s2", 0, 1, 1'b1, 320, 240, 1'b1);
    drain();

    // Reset asserted mid-frame clears outputs at once; release with frame_clk
    // and fire already high must neither tick nor spawn.
    @(negedge CLK);
    frame_clk = 1'b1;
    repeat (8) @(negedge CLK);
    Reset_n = 1'b0;
    #1;
    expect_slot("async_rst_s1", 0, 0, 1'b0, 0, 0, 1'b1);
    expect_slot("async_rst_s2", 0, 1, 1'b0, 0, 0, 1'b1);
    drain();
    fire_a = 1'b1;
    @(negedge CLK);
    Reset_n = 1'b1;
    repeat (8) @(negedge CLK);
    frame_clk = 1'b0;
    repeat (5) @(negedge CLK);
    expect_slot("release_no_spawn", 0, 0, 1'b0, 0, 0, 1'b1);
    drain();
    frame(1'b1, 1'b0, 1'b0, 1'b0);                         // fire held, no new edge
    expect_slot("first_tick_no_spawn", 0, 0, 1'b0, 0, 0, 1'b1);
    drain();

    // Right edge: spawn at X=637 moving +2 px/frame, limit is 639-2=637
    pulse_reset();
    TankX = 10'd637;
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    expect_slot("edge_spawn", 0, 0, 1'b1, 637, 240, 1'b1);
    drain();
    idle_frames(1);
`ifdef BULLET_BOUNCE_EN
    expect_slot("edge_hit", 0, 0, 1'b1, 637, 240, 1'b1);
`else
    expect_slot("edge_hit", 0, 0, 1'b0, 0, 0, 1'b0);
`endif
    drain();
    idle_frames(1);
`ifdef BULLET_BOUNCE_EN
    expect_slot("edge_after", 0, 0, 1'b1, 635, 240, 1'b1);
`else
    expect_slot("edge_after", 0, 0, 1'b0, 0, 0, 1'b0);
`endif
    drain();

    // Pool: stationary bullets, life 8, no cooldown
    pulse_reset();
    TankX = 10'd100;
    TankY = 10'd200;
    cos_t = 8'd0;
    sin_t = 8'd0;
    frame(1'b0, 1'b1, 1'b0, 1'b0);                         // t0 -> slot1
    frame(1'b0, 1'b1, 1'b0, 1'b0);                         // t1 -> slot2
    expect_slot("pool_t1_s2", 1, 1, 1'b1, 100, 200, 1'b1);
    expect_slot("pool_t1_s3", 1, 2, 1'b0, 0, 0, 1'b1);
    drain();
    frame(1'b0, 1'b1, 1'b0, 1'b0);                         // t2 -> slot3
    TankX = 10'd120;
    frame(1'b0, 1'b1, 1'b0, 1'b0);                         // t3 -> dropped
    for (int s = 0; s < 3; s++)
      expect_slot($sformatf("pool_full_s%0d", s), 1, s, 1'b1, 100, 200, 1'b1);
    drain();
    idle_frames(4);                                         // t4..t7
    TankX = 10'd150;
    frame(1'b0, 1'b1, 1'b0, 1'b0);                         // t8: slot1 retires and is reused
    expect_slot("reuse_t8_s1", 1, 0, 1'b1, 150, 200, 1'b1);
    expect_slot("reuse_t8_s2", 1, 1, 1'b1, 100, 200, 1'b1);
    drain();
    TankX = 10'd160;
    frame(1'b0, 1'b1, 1'b0, 1'b0);                         // t9: slot2 retires and is reused
    expect_slot("reuse_t9_s1", 1, 0, 1'b1, 150, 200, 1'b1);
    expect_slot("reuse_t9_s2", 1, 1, 1'b1, 160, 200, 1'b1);
    expect_slot("reuse_t9_s3", 1, 2, 1'b1, 100, 200, 1'b1);
    drain();

    // Lifetime 3 with the fire edge on the tick cycle
    pulse_reset();
    TankX = 10'd50;
    TankY = 10'd60;
    frame(1'b0, 1'b0, 1'b1, 1'b1);                         // spawn on this tick
    expect_slot("life_t0", 2, 0, 1'b1, 50, 60, 1'b1);
    drain();
    idle_frames(1);
    expect_slot("life_t1", 2, 0, 1'b1, 50, 60, 1'b1);
    drain();
    idle_frames(1);
    expect_slot("life_t2", 2, 0, 1'b1, 50, 60, 1'b1);
    drain();
    idle_frames(1);
    expect_slot("life_t3", 2, 0, 1'b0, 50, 60, 1'b1);
    expect_slot("life_t3_s2", 2, 1, 1'b0, 0, 0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
